// File: rtl/pc_seq.sv
// pc_seq: program counter sequencer with page-composed jumps, skip flushes
// and a shift-register hardware return stack.
module pc_seq #(
    parameter int PC_WIDTH = 11,
    parameter int STACK_DEPTH = 2,
    parameter logic [PC_WIDTH-1:0] RESET_VEC = '1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                q1,
    input  logic                q4,
    input  logic [8:0]          ir,
    input  logic [2:0]          pa,
    input  logic                op_goto,
    input  logic                op_call,
    input  logic                op_retlw,
    input  logic                op_skip,
    input  logic                pcl_we,
    input  logic [7:0]          pcl_data,
    output logic [PC_WIDTH-1:0] pc,
    output logic                flush,
    output logic [3:0]          sp,
    output logic                stk_ovf,
    output logic                stk_unf
);
    localparam logic [3:0] DEPTH = 4'(STACK_DEPTH);

    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] r_stk [STACK_DEPTH];
    logic                r_jump, r_flush, r_ovf, r_unf;
    logic [3:0]          r_sp;
    logic                w_ret, w_call, w_goto, w_pclw, w_skip, w_load;
    logic [PC_WIDTH-1:0] w_target;
    logic                w_unused_pa0;

    assign w_ret  = q4 & op_retlw;
    assign w_call = q4 & op_call & ~op_retlw;
    assign w_goto = q4 & op_goto & ~op_call & ~op_retlw;
    assign w_pclw = q4 & pcl_we & ~op_goto & ~op_call & ~op_retlw;
    assign w_skip = q4 & op_skip & ~pcl_we & ~op_goto & ~op_call & ~op_retlw;
    assign w_load = w_ret | w_call | w_goto | w_pclw;
    assign w_unused_pa0 = pa[0];

    // Page bits that fall beyond PC_WIDTH are dropped by the size casts.
    always_comb
        w_target = w_ret  ? r_stk[0] :
                   w_call ? PC_WIDTH'({pa[2:1], 1'b0, ir[7:0]}) :
                   w_goto ? PC_WIDTH'({pa[2:1], ir}) :
                            PC_WIDTH'({pa[2:1], 1'b0, pcl_data});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= RESET_VEC;
            r_jump  <= 1'b1;
            r_flush <= 1'b1;
            r_sp    <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) r_stk[i] <= '0;
        end else begin
            // An execute strobe owns the cycle; a coincident fetch strobe is ignored.
            if (w_load) begin
                r_pc    <= w_target;
                r_jump  <= 1'b1;
                r_flush <= 1'b1;
            end else if (w_skip) begin
                r_flush <= 1'b1;
            end else if (q1 && !q4) begin
                if (!r_jump) r_pc <= r_pc + PC_WIDTH'(1);
                r_jump  <= 1'b0;
                r_flush <= 1'b0;
            end
            if (w_call) begin
                for (int i = 1; i < STACK_DEPTH; i++) r_stk[i] <= r_stk[i-1];
                r_stk[0] <= r_pc;
                if (r_sp == DEPTH) r_ovf <= 1'b1;
                else r_sp <= r_sp + 4'd1;
            end else if (w_ret) begin
                for (int i = 0; i < STACK_DEPTH - 1; i++) r_stk[i] <= r_stk[i+1];
                if (r_sp == 4'd0) r_unf <= 1'b1;
                else r_sp <= r_sp - 4'd1;
            end
        end
    end

    assign pc      = r_pc;
    assign flush   = r_flush;
    assign sp      = r_sp;
    assign stk_ovf = r_ovf;
    assign stk_unf = r_unf;
endmodule

// File: tb/tb_pc_seq.sv
// tb_pc_seq: vector table, multi-cycle corner sequences and a randomized run
// against a queue-based reference model of pc_seq.
module tb_pc_seq;
    localparam int PW = 11;
    localparam int DEPTH = 2;
    localparam int PMASK = (1 << PW) - 1;
    localparam logic [6:0] Q1 = 7'b1000000, Q4 = 7'b0100000, G = 7'b0010000,
                           C = 7'b0001000, R = 7'b0000100, S = 7'b0000010,
                           W = 7'b0000001;

    logic clk = 1'b0, rst_n = 1'b0;
    logic q1 = 0, q4 = 0, op_goto = 0, op_call = 0, op_retlw = 0, op_skip = 0, pcl_we = 0;
    logic [8:0] ir = '0;
    logic [2:0] pa = '0;
    logic [7:0] pcl_data = '0;
    logic [PW-1:0] pc;
    logic flush, stk_ovf, stk_unf;
    logic [3:0] sp;

    int n_checks = 0, n_err = 0;

    pc_seq dut (
        .clk(clk), .rst_n(rst_n), .q1(q1), .q4(q4), .ir(ir), .pa(pa),
        .op_goto(op_goto), .op_call(op_call), .op_retlw(op_retlw), .op_skip(op_skip),
        .pcl_we(pcl_we), .pcl_data(pcl_data), .pc(pc), .flush(flush), .sp(sp),
        .stk_ovf(stk_ovf), .stk_unf(stk_unf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]    ctl;
        logic [8:0]    ir;
        logic [2:0]    pa;
        logic [7:0]    d;
        logic [PW-1:0] pc;
        logic          flush;
        logic [3:0]    sp;
    } vec_t;
    vec_t tbl [24];

    // Reference model: plain integers and a queue whose front is the stack top.
    int m_pc, m_sp;
    bit m_jump, m_flush, m_ovf, m_unf;
    int m_stk [$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic drive(input logic [6:0] ctl, input logic [8:0] i, input logic [2:0] p, input logic [7:0] d);
        {q1, q4, op_goto, op_call, op_retlw, op_skip, pcl_we} = ctl;
        ir = i;
        pa = p;
        pcl_data = d;
    endtask

    task automatic cyc(input logic [6:0] ctl, input logic [8:0] i, input logic [2:0] p, input logic [7:0] d);
        drive(ctl, i, p, d);
        @(posedge clk);
        #1;
        drive(7'b0, 9'h0, 3'h0, 8'h0);
    endtask

    task automatic model_reset();
        m_pc = PMASK;
        m_jump = 1;
        m_flush = 1;
        m_sp = 0;
        m_ovf = 0;
        m_unf = 0;
        m_stk.delete();
        for (int i = 0; i < DEPTH; i++) m_stk.push_back(0);
    endtask

    task automatic model_step(input logic [6:0] ctl, input int i, input int p, input int d);
        int page, v;
        page = (p >> 1) & 3;
        if (ctl[5] && (ctl[2] || ctl[3] || ctl[4] || ctl[0])) begin
            if (ctl[2]) begin
                v = m_stk.pop_front();
                m_stk.push_back(m_stk.size() > 0 ? m_stk[$] : v);
                m_pc = v;
                if (m_sp == 0) m_unf = 1; else m_sp--;
            end else if (ctl[3]) begin
                m_stk.push_front(m_pc);
                void'(m_stk.pop_back());
                if (m_sp == DEPTH) m_ovf = 1; else m_sp++;
                m_pc = (page * 512 + (i % 256)) & PMASK;
            end else if (ctl[4]) m_pc = (page * 512 + i) & PMASK;
            else m_pc = (page * 512 + d) & PMASK;
            m_jump = 1;
            m_flush = 1;
        end else if (ctl[5] && ctl[1]) m_flush = 1;
        else if (ctl[6] && !ctl[5]) begin
            if (!m_jump) m_pc = (m_pc + 1) & PMASK;
            m_jump = 0;
            m_flush = 0;
        end
    endtask

    initial begin
        tbl[0]  = '{Q1,          9'h000, 3'd0, 8'h00, 11'h7FF, 1'b0, 4'd0};
        tbl[1]  = '{Q1,          9'h000, 3'd0, 8'h00, 11'h000, 1'b0, 4'd0};
        tbl[2]  = '{Q1,          9'h000, 3'd0, 8'h00, 11'h001, 1'b0, 4'd0};
        tbl[3]  = '{Q4|G,        9'h155, 3'd4, 8'h00, 11'h555, 1'b1, 4'd0};
        tbl[4]  = '{Q1,          9'h000, 3'd0, 8'h00, 11'h555, 1'b0, 4'd0};
        tbl[5]  = '{Q1,          9'h000, 3'd0, 8'h00, 11'h556, 1'b0, 4'd0};
        tbl[6]  = '{Q4|G,        9'h020, 3'd0, 8'h00, 11'h020, 1'b1, 4'd0};
        tbl[7]  = '{Q1,          9'h000, 3'd0, 8'h00, 11'h020, 1'b0, 4'd0};
        tbl[8]  = '{Q1,          9'h000, 3'd0, 8'h00, 11'h021, 1'b0, 4'd0};
        tbl[9]  = '{Q4|C,        9'h080, 3'd0, 8'h00, 11'h080, 1'b1, 4'd1};
        tbl[10] = '{Q1,          9'h000, 3'd0, 8'h00, 11'h080, 1'b0, 4'd1};
        tbl[11] = '{Q4|R,        9'h000, 3'd0, 8'h00, 11'h021, 1'b1, 4'd0};
        tbl[12] = '{Q1,          9'h000, 3'd0, 8'h00, 11'h021, 1'b0, 4'd0};
        tbl[13] = '{Q1,          9'h000, 3'd0, 8'h00, 11'h022, 1'b0, 4'd0};
        tbl[14] = '{Q4|S,        9'h000, 3'd0, 8'h00, 11'h022, 1'b1, 4'd0};
        tbl[15] = '{Q1,          9'h000, 3'd0, 8'h00, 11'h023, 1'b0, 4'd0};
        tbl[16] = '{Q4|W,        9'h000, 3'd4, 8'hFE, 11'h4FE, 1'b1, 4'd0};
        tbl[17] = '{Q1,          9'h000, 3'd0, 8'h00, 11'h4FE, 1'b0, 4'd0};
        tbl[18] = '{Q4|G|S,      9'h100, 3'd0, 8'h00, 11'h100, 1'b1, 4'd0};
        tbl[19] = '{Q1,          9'h000, 3'd0, 8'h00, 11'h100, 1'b0, 4'd0};
        tbl[20] = '{Q1|Q4|C,     9'h033, 3'd6, 8'h00, 11'h633, 1'b1, 4'd1};
        tbl[21] = '{Q1,          9'h000, 3'd0, 8'h00, 11'h633, 1'b0, 4'd1};
        tbl[22] = '{Q4|R|C|G|W|S, 9'h0AA, 3'd2, 8'h55, 11'h100, 1'b1, 4'd0};
        tbl[23] = '{Q1,          9'h000, 3'd0, 8'h00, 11'h100, 1'b0, 4'd0};

        @(posedge clk);
        #1;
        chk("reset_pc", pc, 11'h7FF);
        chk("reset_flush", flush, 1'b1);
        chk("reset_sp", sp, 4'd0);
        chk("reset_flags", {stk_ovf, stk_unf}, 2'b00);
        rst_n = 1'b1;

        for (int k = 0; k < 24; k++) begin
            cyc(tbl[k].ctl, tbl[k].ir, tbl[k].pa, tbl[k].d);
            chk($sformatf("vec%0d_pc", k), pc, tbl[k].pc);
            chk($sformatf("vec%0d_flush", k), flush, tbl[k].flush);
            chk($sformatf("vec%0d_sp", k), sp, tbl[k].sp);
        end
        chk("vec_flags", {stk_ovf, stk_unf}, 2'b00);

        // Overflow then underflow with a two-entry stack.
        cyc(Q4|G, 9'h010, 3'd0, 8'h00);
        cyc(Q4|C, 9'h020, 3'd0, 8'h00);
        cyc(Q1, 9'h0, 3'd0, 8'h0);
        cyc(Q1, 9'h0, 3'd0, 8'h0);
        chk("ovf_pc_a", pc, 11'h021);
        cyc(Q4|C, 9'h040, 3'd0, 8'h00);
        cyc(Q1, 9'h0, 3'd0, 8'h0);
        cyc(Q1, 9'h0, 3'd0, 8'h0);
        cyc(Q4|C, 9'h060, 3'd0, 8'h00);
        chk("ovf_pc", pc, 11'h060);
        chk("ovf_sp", sp, 4'd2);
        chk("ovf_flag", stk_ovf, 1'b1);
        chk("ovf_unf_clear", stk_unf, 1'b0);
        cyc(Q4|R, 9'h0, 3'd0, 8'h0);
        chk("ret1_pc", pc, 11'h041);
        chk("ret1_sp", sp, 4'd1);
        cyc(Q4|R, 9'h0, 3'd0, 8'h0);
        chk("ret2_pc", pc, 11'h021);
        chk("ret2_sp", sp, 4'd0);
        chk("ret2_unf", stk_unf, 1'b0);
        cyc(Q4|R, 9'h0, 3'd0, 8'h0);
        chk("ret3_pc_stale", pc, 11'h021);
        chk("ret3_sp", sp, 4'd0);
        chk("ret3_unf", stk_unf, 1'b1);
        cyc(Q1, 9'h0, 3'd0, 8'h0);
        cyc(Q1, 9'h0, 3'd0, 8'h0);
        chk("sticky_ovf", stk_ovf, 1'b1);
        chk("sticky_unf", stk_unf, 1'b1);

        // Asynchronous reset in the middle of a strobe with a request pending.
        cyc(Q4|W, 9'h0, 3'd4, 8'hFE);
        chk("pcl_pc", pc, 11'h4FE);
        drive(Q4|G, 9'h123, 3'd2, 8'h00);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_pc", pc, 11'h7FF);
        chk("async_flush", flush, 1'b1);
        chk("async_sp", sp, 4'd0);
        chk("async_flags", {stk_ovf, stk_unf}, 2'b00);
        @(posedge clk);
        #1;
        chk("held_pc", pc, 11'h7FF);
        drive(7'b0, 9'h0, 3'h0, 8'h0);
        rst_n = 1'b1;
        cyc(Q1, 9'h0, 3'd0, 8'h0);
        chk("post_rst_q1a", pc, 11'h7FF);
        chk("post_rst_flush", flush, 1'b0);
        cyc(Q1, 9'h0, 3'd0, 8'h0);
        chk("post_rst_q1b", pc, 11'h000);

        // Randomized run against the reference model.
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 3000; k++) begin
            logic [6:0] ctl;
            logic [8:0] ri;
            logic [2:0] rp;
            logic [7:0] rd;
            int sel;
            sel = $urandom_range(0, 3);
            ri = 9'($urandom);
            rp = 3'($urandom);
            rd = 8'($urandom);
            ctl = (sel == 0) ? 7'b0 : (sel == 1) ? Q1 : (Q4 | 7'($urandom_range(0, 31)));
            model_step(ctl, int'(ri), int'(rp), int'(rd));
            cyc(ctl, ri, rp, rd);
            chk("rnd_pc", pc, m_pc);
            chk("rnd_flush", flush, m_flush);
            chk("rnd_sp", sp, m_sp);
            chk("rnd_ovf", stk_ovf, m_ovf);
            chk("rnd_unf", stk_unf, m_unf);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
